jtag_multi_ctrl_port: RTL and testbench
=======================================

# jtag_multi_ctrl_port

Parametrised virtual-JTAG register bank: the next generation of the single-register JTAG control port. It exposes NCH independent DW-bit control registers, written from the host, and NCH DW-bit status inputs, read back by the host. Channels are selected by an address instruction, with optional auto-increment for burst access. The block sits between a vjtag instance and the fabric, and runs entirely in the tck domain.

## Interface
- DW, 32: data width of each channel (DW >= 1).
- NCH, 4: number of channels (1..2^AW).
- AW, 2: channel-address width.
- IRW, 3: virtual IR width.
- AUTO_INC, 1: 1 = address increments after every WRITE/READ update; 0 = address is static.
- clk  in  1  vjtag tck; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- ir_in  in  IRW  virtual IR from vjtag.
- ir_out  out  IRW  equal to ir_in (combinational pass-through).
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- cdr, sdr, udr, uir  in  1 each  vjtag virtual-state strobes (capture-DR, shift-DR, update-DR, update-IR).
- ctrl_out  out  NCH*DW  control registers; channel k occupies [k*DW +: DW].
- wr_stb  out  NCH  one-cycle pulse on the channel written.
- stat_in  in  NCH*DW  status words, sampled at capture.
- rd_stb  out  NCH  one-cycle pulse on the channel captured.

## Operation
- Instruction register `ir` (IRW bits) loads ir_in on a clk edge with uir=1.
- Instruction codes:
  - 0 BYPASS
  - 1 ADDR
  - 2 WRITE
  - 3 READ
  - 4 INFO
  - any other code behaves as BYPASS.
- BYPASS: the 1-bit bypass_reg loads tdi every cycle; tdo = bypass_reg.
- Common shift register `sbuf` (DW bits) and address shift register `asr` (AW bits):
  - sdr: sbuf <= {tdi, sbuf[DW-1:1]}; for DW==1, sbuf <= tdi.
  - asr shifts the same way, only when ir==ADDR.
  - tdo = asr[0] under ADDR; tdo = sbuf[0] under WRITE/READ/INFO.
- ADDR:
  - cdr: asr <= addr.
  - udr: addr <= asr.
- WRITE:
  - cdr: sbuf <= ctrl_out[addr], or 0 if addr >= NCH. The host reads the old value while shifting in the new one.
  - udr with addr < NCH: ctrl_out[addr] <= sbuf and wr_stb[addr]=1 for that one cycle.
  - udr with addr >= NCH: no register change, no strobe.
- READ:
  - cdr: sbuf <= stat_in[addr], or 0 if addr >= NCH; rd_stb[addr]=1 for that cycle when addr < NCH.
  - udr: no data action.
- Auto-increment: when AUTO_INC=1, udr under WRITE or READ updates addr <= (addr==NCH-1 || addr>=NCH) ? 0 : addr+1.
- INFO:
  - cdr: sbuf <= {zero-extended NCH in bits [15:8], DW[7:0]}, truncated or zero-extended to DW.
  - udr: no action.
- Priority when strobes overlap (illegal in TAP, but defined): cdr > sdr; udr is evaluated independently of both.
- Reset values: ir=0, bypass_reg=0, sbuf=0, asr=0, addr=0, ctrl_out=0, wr_stb=0, rd_stb=0. Hence tdo=0 after reset.

## Timing
- All state is registered on posedge clk; reset clears all of it asynchronously, including mid-shift, and resumes in BYPASS.
- wr_stb and rd_stb are registered pulses, high for exactly one clk cycle, in the cycle after the udr/cdr edge.
- ctrl_out updates on the same edge that samples udr.
- tdo is combinational from registers, valid in the cycle after each shift edge.
- Capture latency: stat_in is sampled on the cdr edge; the first bit is available on tdo the next cycle.
- Each WRITE scan shifts DW bits; a longer scan leaves the last DW bits in sbuf.

## Test plan
- Reset, then shift 1,0,1,1 under BYPASS -> tdo echoes tdi delayed by one clk; ctrl_out=0; no strobes.
- DW=32, NCH=4: ADDR scan with 2'b10, then WRITE 0xDEADBEEF -> ctrl_out[2]=0xDEADBEEF, wr_stb=4'b0100 for one cycle, addr=3 (AUTO_INC=1).
- Continue with WRITE 0x1 and WRITE 0x2 -> ctrl_out[3]=0x1, then wrap: ctrl_out[0]=0x2. A WRITE scan to ch3 shifts out the previous 0x1 during capture.
- stat_in ch1=0xA5A5_0001; ADDR 1, READ -> tdo emits 0xA5A50001 LSB first; rd_stb=4'b0010 for one cycle.
- NCH=3: ADDR 3, WRITE 0xFFFF_FFFF -> no ctrl_out change, wr_stb stays 0, addr wraps to 0. READ at addr 3 -> shifts 0.
- Assert reset mid WRITE shift (bit 10 of 32) -> every register 0 immediately; the following udr produces no strobe because ir=BYPASS.

Source files
------------

// File: rtl/jtag_multi_ctrl_port.sv
// jtag_multi_ctrl_port: virtual-JTAG register bank with NCH control registers
// (host writes) and NCH status inputs (host reads). A channel is selected by an
// ADDR scan and may auto-increment after every WRITE/READ update so the host can
// burst through the channels. All logic runs in the tck domain.
module jtag_multi_ctrl_port #(
    parameter int DW       = 32,
    parameter int NCH      = 4,
    parameter int AW       = 2,
    parameter int IRW      = 3,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IRW-1:0]    ir_in,
    output logic [IRW-1:0]    ir_out,
    input  logic              tdi,
    output logic              tdo,
    input  logic              cdr,
    input  logic              sdr,
    input  logic              udr,
    input  logic              uir,
    output logic [NCH*DW-1:0] ctrl_out,
    output logic [NCH-1:0]    wr_stb,
    input  logic [NCH*DW-1:0] stat_in,
    output logic [NCH-1:0]    rd_stb
);

    localparam logic [IRW-1:0] IR_BYPASS = IRW'(0);
    localparam logic [IRW-1:0] IR_ADDR   = IRW'(1);
    localparam logic [IRW-1:0] IR_WRITE  = IRW'(2);
    localparam logic [IRW-1:0] IR_READ   = IRW'(3);
    localparam logic [IRW-1:0] IR_INFO   = IRW'(4);

    // Channel count widened by one bit so the wrap test also covers addr >= NCH.
    localparam logic [AW:0]    NCH_W      = (AW+1)'(NCH);
    localparam logic [15:0]    INFO16     = {8'(NCH), 8'(DW)};
    localparam logic [DW-1:0]  INFO_WORD  = DW'(INFO16);

    logic [IRW-1:0]    ir_q,     ir_d;
    logic              bypass_q, bypass_d;
    logic [DW-1:0]     sbuf_q,   sbuf_d;
    logic [AW-1:0]     asr_q,    asr_d;
    logic [AW-1:0]     addr_q,   addr_d;
    logic [NCH*DW-1:0] ctrl_q,   ctrl_d;
    logic [NCH-1:0]    wr_stb_q, wr_stb_d;
    logic [NCH-1:0]    rd_stb_q, rd_stb_d;

    logic [DW-1:0]     sbuf_shift;
    logic [AW-1:0]     asr_shift;
    logic [DW-1:0]     sel_ctrl;
    logic [DW-1:0]     sel_stat;
    logic [NCH-1:0]    addr_onehot;
    logic [AW:0]       addr_plus;
    logic [AW-1:0]     addr_inc;

    // Right-shift paths; a one-bit register simply takes tdi.
    if (DW == 1) begin : g_sbuf_1
        assign sbuf_shift = tdi;
    end else begin : g_sbuf_n
        assign sbuf_shift = {tdi, sbuf_q[DW-1:1]};
    end

    if (AW == 1) begin : g_asr_1
        assign asr_shift = tdi;
    end else begin : g_asr_n
        assign asr_shift = {tdi, asr_q[AW-1:1]};
    end

    // Channel decode: unmapped addresses match no channel, so they read 0 and write nothing.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sel_ctrl    = '0;
        sel_stat    = '0;
        addr_onehot = '0;
        for (int k = 0; k < NCH; k++) begin
            if (addr_q == AW'(k)) begin
                sel_ctrl       = ctrl_q[k*DW +: DW];
                sel_stat       = stat_in[k*DW +: DW];
                addr_onehot[k] = 1'b1;
            end
        end
    end

    // Auto-increment target: wraps to 0 from the last channel or any unmapped address.
    always_comb begin
        addr_plus = {1'b0, addr_q} + (AW+1)'(1);
        addr_inc  = (addr_plus >= NCH_W) ? '0 : addr_plus[AW-1:0];
    end

    // Next-state for the IR, shift registers, address and control bank.
    always_comb begin
        ir_d     = uir ? ir_in : ir_q;
        bypass_d = tdi;
        sbuf_d   = sbuf_q;
        asr_d    = asr_q;
        addr_d   = addr_q;
        ctrl_d   = ctrl_q;
        wr_stb_d = '0;
        rd_stb_d = '0;

        // Capture wins over shift when both strobes are seen together.
        if (cdr) begin
            case (ir_q)
                IR_ADDR:  asr_d = addr_q;
                IR_WRITE: sbuf_d = sel_ctrl;
                IR_READ: begin
                    sbuf_d   = sel_stat;
                    rd_stb_d = addr_onehot;
                end
                IR_INFO:  sbuf_d = INFO_WORD;
                default: ;
            endcase
        end else if (sdr) begin
            sbuf_d = sbuf_shift;
            if (ir_q == IR_ADDR) begin
                asr_d = asr_shift;
            end
        end

        // Update is evaluated independently of capture/shift.
        if (udr) begin
            case (ir_q)
                IR_ADDR: addr_d = asr_q;
                IR_WRITE: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (addr_onehot[k]) begin
                            ctrl_d[k*DW +: DW] = sbuf_q;
                        end
                    end
                    wr_stb_d = addr_onehot;
                    if (AUTO_INC != 0) begin
                        addr_d = addr_inc;
                    end
                end
                IR_READ: begin
                    if (AUTO_INC != 0) begin
                        addr_d = addr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; reset returns the port to BYPASS with every register cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q     <= IR_BYPASS;
            bypass_q <= 1'b0;
            sbuf_q   <= '0;
            asr_q    <= '0;
            addr_q   <= '0;
            ctrl_q   <= '0;
            wr_stb_q <= '0;
            rd_stb_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            ir_q     <= ir_d;
            bypass_q <= bypass_d;
            sbuf_q   <= sbuf_d;
            asr_q    <= asr_d;
            addr_q   <= addr_d;
            ctrl_q   <= ctrl_d;
            wr_stb_q <= wr_stb_d;
            rd_stb_q <= rd_stb_d;
        end
    end

    // Serial output selects the register that the current instruction shifts.
    always_comb begin
        case (ir_q)
            IR_ADDR:                    tdo = asr_q[0];
            IR_WRITE, IR_READ, IR_INFO: tdo = sbuf_q[0];
            default:                    tdo = bypass_q;
        endcase
    end

    assign ir_out   = ir_in;
    assign ctrl_out = ctrl_q;
    assign wr_stb   = wr_stb_q;
    assign rd_stb   = rd_stb_q;

endmodule

// File: tb/tb_jtag_multi_ctrl_port.sv
// Testbench for jtag_multi_ctrl_port with NCH=3 so that address 3 is unmapped.
// A scan-level model predicts captured words, shifted-out bits, strobes and the
// control bank; directed scenarios are followed by randomized scans.
module tb_jtag_multi_ctrl_port;

    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int AW  = 2;
    localparam int IRW = 3;

    logic              clk;
    logic              rst_n;
    logic [IRW-1:0]    ir_in;
    logic [IRW-1:0]    ir_out;
    logic              tdi;
    logic              tdo;
    logic              cdr, sdr, udr, uir;
    logic [NCH*DW-1:0] ctrl_out;
    logic [NCH-1:0]    wr_stb;
    logic [NCH*DW-1:0] stat_in;
    logic [NCH-1:0]    rd_stb;

    jtag_multi_ctrl_port #(
        .DW(DW), .NCH(NCH), .AW(AW), .IRW(IRW), .AUTO_INC(1)
    ) dut (
        .clk(clk), .reset(rst_n), .ir_in(ir_in), .ir_out(ir_out),
        .tdi(tdi), .tdo(tdo), .cdr(cdr), .sdr(sdr), .udr(udr), .uir(uir),
        .ctrl_out(ctrl_out), .wr_stb(wr_stb), .stat_in(stat_in), .rd_stb(rd_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: current instruction, selected channel, control words.
    int            m_ir;
    int            m_addr;
    logic [DW-1:0] m_ctrl [NCH];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_ctrl();
        logic [127:0] r = '0;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = m_ctrl[k];
        return r;
    endfunction

    function automatic int next_addr(input int a);
        return (a >= NCH - 1) ? 0 : a + 1;
    endfunction

    task automatic model_reset();
        m_ir   = 0;
        m_addr = 0;
        for (int k = 0; k < NCH; k++) m_ctrl[k] = '0;
    endtask

    // Inputs change on the falling edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ir(input int code);
        ir_in = IRW'(code);
        uir   = 1'b1;
        check("ir_out_pass", 128'(ir_out), 128'(code));
        tick();
        uir  = 1'b0;
        m_ir = code;
    endtask

    // One capture / n-bit shift / update sequence checked against the model.
    task automatic dr_scan(input logic [63:0] din_raw, input int n);
        int            w;
        logic [DW-1:0] cap;
        logic [63:0]   din;
        logic [63:0]   dout;
        logic [127:0]  comb;
        logic [127:0]  fin;
        logic [127:0]  nmask;
        logic [NCH-1:0] exp_rd;
        logic [NCH-1:0] exp_wr;
        bit            valid;

        valid  = (m_addr < NCH);
        exp_rd = '0;
        exp_wr = '0;
        case (m_ir)
            1: begin w = AW; cap = DW'(m_addr); end
            2: begin w = DW; cap = valid ? m_ctrl[m_addr] : '0; end
            3: begin
                w   = DW;
                cap = valid ? stat_in[m_addr*DW +: DW] : '0;
                if (valid) exp_rd = NCH'(1) << m_addr;
            end
            4: begin w = DW; cap = DW'(32'h0000_0320); end
            default: begin w = 1; cap = '0; end
        endcase

        din   = din_raw & ((64'd1 << n) - 64'd1);
        comb  = ({64'd0, din} << w) | 128'(cap);
        nmask = (128'd1 << n) - 128'd1;
        fin   = (comb >> n) & ((128'd1 << w) - 128'd1);

        cdr = 1'b1;
        tick();
        cdr = 1'b0;
        check("rd_stb_capture", 128'(rd_stb), 128'(exp_rd));

        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tdi     = din[i];
            sdr     = 1'b1;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
        check("tdo_stream", 128'(dout) & nmask, comb & nmask);

        if (m_ir == 1) begin
            m_addr = int'(fin[AW-1:0]);
        end else if (m_ir == 2) begin
            if (valid) begin
                m_ctrl[m_addr] = fin[DW-1:0];
                exp_wr = NCH'(1) << m_addr;
            end
            m_addr = next_addr(m_addr);
        end else if (m_ir == 3) begin
            m_addr = next_addr(m_addr);
        end

        udr = 1'b1;
        tick();
        udr = 1'b0;
        check("wr_stb_update", 128'(wr_stb), 128'(exp_wr));
        check("ctrl_out", 128'(ctrl_out), model_ctrl());
        tick();
        check("strobes_clear", 128'({wr_stb, rd_stb}), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r64;

        rst_n = 1'b0;
        ir_in = '0; tdi = 1'b0;
        cdr = 1'b0; sdr = 1'b0; udr = 1'b0; uir = 1'b0;
        stat_in = '0;
        model_reset();
        tick();
        tick();
        check("reset_tdo", 128'(tdo), 128'(0));
        check("reset_ctrl", 128'(ctrl_out), 128'(0));
        check("reset_strobes", 128'({wr_stb, rd_stb}), 128'(0));
        rst_n = 1'b1;
        tick();

        // BYPASS echo of 1,0,1,1 delayed by one clock.
        load_ir(0);
        dr_scan(64'b1101, 4);

        // Address 2, then a burst of writes wrapping 2 -> 0 -> 1.
        load_ir(1); dr_scan(64'd2, AW);
        load_ir(2); dr_scan(64'hDEAD_BEEF, DW);
        dr_scan(64'h1, DW);
        dr_scan(64'h2, DW);
        // Rewriting channel 2 shifts out its previous 0xDEADBEEF.
        dr_scan(64'h1234_5678, DW);

        // Status read of channel 1.
        stat_in = {32'h0BAD_F00D, 32'hA5A5_0001, 32'h5555_AAAA};
        load_ir(1); dr_scan(64'd1, AW);
        load_ir(3); dr_scan(64'd0, DW);

        // Unmapped address 3: write ignored, read returns 0, address wraps.
        load_ir(1); dr_scan(64'd3, AW);
        load_ir(2); dr_scan(64'hFFFF_FFFF, DW);
        load_ir(1); dr_scan(64'd3, AW);
        load_ir(3); dr_scan(64'hFFFF_FFFF, DW);

        // Identity word, an unknown opcode, and an over-long write scan.
        load_ir(4); dr_scan(64'd0, DW);
        load_ir(6); dr_scan(64'b1011_0110, 8);
        load_ir(1); dr_scan(64'd0, AW);
        load_ir(2); dr_scan(64'hC3_8765_4321, 40);

        // Reset asserted mid write-shift clears everything at once.
        load_ir(1); dr_scan(64'd1, AW);
        load_ir(2);
        cdr = 1'b1; tick(); cdr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tdi = 1'($urandom);
            sdr = 1'b1;
            tick();
        end
        sdr   = 1'b0;
        tdi   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midshift_rst_tdo", 128'(tdo), 128'(0));
        check("midshift_rst_ctrl", 128'(ctrl_out), 128'(0));
        check("midshift_rst_strobes", 128'({wr_stb, rd_stb}), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        udr = 1'b1; tick(); udr = 1'b0;
        check("post_rst_udr_wr_stb", 128'(wr_stb), 128'(0));
        check("post_rst_udr_ctrl", 128'(ctrl_out), 128'(0));
        dr_scan(64'b0110, 4);

        // Randomized scans.
        for (int it = 0; it < 80; it++) begin
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: begin load_ir(1); dr_scan(r64, $urandom_range(AW, AW + 3)); end
                1: begin load_ir(2); dr_scan(r64, $urandom_range(1, 40)); end
                2: begin
                    stat_in = {$urandom, $urandom, $urandom};
                    load_ir(3);
                    dr_scan(r64, $urandom_range(1, 34));
                end
                3: begin load_ir(4); dr_scan(r64, $urandom_range(1, 34)); end
                4: begin
                    load_ir(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 7));
                    dr_scan(r64, $urandom_range(1, 8));
                end
                default: begin
                    stat_in = {$urandom, $urandom, $urandom};
                    dr_scan(r64, $urandom_range(1, 36));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
